// File: rtl/mem_port_arbiter_pkg.sv
// riscy_mem_pkg: shared types and defaults for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   port_t      : identifies the I (fetch) or D (load/store) requester
//   DEF_AW/DW   : default address / data widths
package riscy_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the I port, D port and memory-side signals.
//   slave  : arbiter view (takes requests, drives grants/responses and memory)
//   master : core + memory view (drives requests and mem_rdata)
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[0] = I port, req[1] = D port
//   last_grant : port granted most recently (register kept by the parent)
//   grant      : one-hot winner, all-zero when nothing requests
module rr_arb2
    import riscy_mem_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (&req) begin
            // Contention: the port that did not win last time goes now.
            grant = (last_grant == PORT_I) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between the
// instruction-fetch port (I, read-only) and the load/store port (D).
// One transaction in flight, round-robin on contention.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : I/D request/response and memory signals (slave modport)
//   busy       : high whenever the FSM is not in IDLE
// Parameters: AW/DW widths, RD_LAT memory read latency (1..4 cycles).
module mem_port_arbiter
    import riscy_mem_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    arb_state_t    state;
    port_t         owner;
    port_t         last_grant;
    logic          lat_we;
    logic [1:0]    cnt;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [1:0]    pick;
    logic [1:0]    gnt;

    rr_arb2 u_pick (
        .req        ({bus.d_req, bus.i_req}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Grants exist only in IDLE and are suppressed while reset is held.
    assign gnt = (rst_n && state == IDLE) ? pick : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= PORT_I;
            last_grant  <= PORT_I;
            lat_we      <= 1'b0;
            cnt         <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        // The address latch doubles as the mem_addr driver, so it
                        // becomes visible in ACCESS and holds afterwards.
                        owner      <= gnt[1] ? PORT_D : PORT_I;
                        last_grant <= gnt[1] ? PORT_D : PORT_I;
                        mem_addr_q <= gnt[1] ? bus.d_addr : bus.i_addr;
                        lat_we     <= gnt[1] & bus.d_we;
                        if (gnt[1]) begin
                            mem_wdata_q <= bus.d_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state <= RESP;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        if (owner == PORT_D) begin
                            d_rdata_q <= bus.mem_rdata;
                        end else begin
                            i_rdata_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_gnt     = gnt[0];
    assign bus.d_gnt     = gnt[1];
    assign bus.i_rvalid  = (state == RESP) && (owner == PORT_I);
    assign bus.d_rvalid  = (state == RESP) && (owner == PORT_D);
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_we    = (state == ACCESS) && lat_we;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state != IDLE);

endmodule
